// File: rtl/pwm_duty_scheduler.sv
// Strobe scheduler for NCH PWM channels: manual edge requests or auto triangle ramp, round-robin grant.
// A request edge produces a registered one-cycle strobe one edge later; grants are spaced 3 cycles; en=0 holds requests.
module pwm_duty_scheduler #(
   parameter int NCH      = 5,
   parameter int STEPS    = 10,
   parameter int TICK_DIV = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 mode,
   input  logic [NCH-1:0]       req_up,
   input  logic [NCH-1:0]       req_dn,
   output logic [NCH-1:0]       increase,
   output logic [NCH-1:0]       decrease,
   output logic [4*NCH-1:0]     duty_lvl,
   output logic                 busy,
   output logic                 overrun
);
   localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [3:0]    LVL_MAX   = 4'(STEPS);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [GW-1:0] LAST_INIT = GW'(NCH - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_t;

   state_t                 state_q, state_d;
   logic [NCH-1:0]         pend_up_q, pend_up_d, pend_dn_q, pend_dn_d;
   logic [NCH-1:0]         req_up_q, req_dn_q;
   logic [NCH-1:0][3:0]    lvl_q, lvl_d;
   logic [NCH-1:0]         dir_q, dir_d;
   logic [TW-1:0]          tick_q, tick_d;
   logic [GW-1:0]          last_q, last_d;
   logic                   overrun_q, overrun_d;
   logic                   mode_q;
   logic [NCH-1:0]         inc_q, inc_d, dec_q, dec_d;

   logic [NCH-1:0]         pend_any, edge_up, edge_dn;
   logic                   mode_chg, tick_wrap, found;
   logic [GW-1:0]          gnt, cand;
   logic [GW:0]            sum;

   assign pend_any = pend_up_q | pend_dn_q;
   assign mode_chg = (mode != mode_q);
   assign edge_up  = req_up & ~req_up_q & {NCH{~mode}};
   assign edge_dn  = req_dn & ~req_dn_q & {NCH{~mode}};
   assign tick_wrap = mode && !mode_chg && en && (tick_q == TICK_LAST);

   // Round-robin: first pending channel at or after last_grant+1, wrapping modulo NCH.
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      sum   = '0;
      cand  = '0;
      for (int k = 0; k < NCH; k++) begin
         sum  = {1'b0, last_q} + (GW+1)'(k + 1);
         cand = (sum >= (GW+1)'(NCH)) ? GW'(sum - (GW+1)'(NCH)) : sum[GW-1:0];
         if (!found && pend_any[cand]) begin
            found = 1'b1;
            gnt   = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      pend_up_d = pend_up_q;
      pend_dn_d = pend_dn_q;
      lvl_d     = lvl_q;
      dir_d     = dir_q;
      tick_d    = tick_q;
      last_d    = last_q;
      overrun_d = overrun_q;
      inc_d     = '0;
      dec_d     = '0;

      case (state_q)
         IDLE: begin
            if (en && found && !mode_chg) begin
               pend_up_d[gnt] = 1'b0;
               pend_dn_d[gnt] = 1'b0;
               // Saturated requests are dropped in place without spending an ISSUE slot.
               if (!((pend_up_q[gnt] && lvl_q[gnt] == LVL_MAX) ||
                     (pend_dn_q[gnt] && lvl_q[gnt] == 4'd0))) begin
                  state_d = ISSUE;
                  last_d  = gnt;
                  if (pend_up_q[gnt]) begin
                     inc_d[gnt] = 1'b1;
                     lvl_d[gnt] = lvl_q[gnt] + 4'd1;
                     if (lvl_q[gnt] + 4'd1 == LVL_MAX) dir_d[gnt] = 1'b1;
                  end else begin
                     dec_d[gnt] = 1'b1;
                     lvl_d[gnt] = lvl_q[gnt] - 4'd1;
                     if (lvl_q[gnt] == 4'd1) dir_d[gnt] = 1'b0;
                  end
               end
            end
         end
         ISSUE:   state_d = GAP;
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (mode && !mode_chg && en) tick_d = tick_wrap ? '0 : tick_q + TW'(1);

      if (tick_wrap) begin
         for (int i = 0; i < NCH; i++) begin
            if (pend_any[i])     overrun_d    = 1'b1;
            else if (dir_q[i])   pend_dn_d[i] = 1'b1;
            else                 pend_up_d[i] = 1'b1;
         end
      end

      if (!mode && !mode_chg) begin
         for (int i = 0; i < NCH; i++) begin
            if (edge_up[i] && edge_dn[i]) begin
               pend_up_d[i] = 1'b0;
               pend_dn_d[i] = 1'b0;
            end else if (edge_up[i]) begin
               if (pend_dn_d[i]) pend_dn_d[i] = 1'b0;
               else              pend_up_d[i] = 1'b1;
            end else if (edge_dn[i]) begin
               if (pend_up_d[i]) pend_up_d[i] = 1'b0;
               else              pend_dn_d[i] = 1'b1;
            end
         end
      end

      if (mode_chg) begin
         pend_up_d = '0;
         pend_dn_d = '0;
         tick_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pend_up_q <= '0;
         pend_dn_q <= '0;
         req_up_q  <= '0;
         req_dn_q  <= '0;
         lvl_q     <= '0;
         dir_q     <= '0;
         tick_q    <= '0;
         last_q    <= LAST_INIT;
         overrun_q <= 1'b0;
         mode_q    <= 1'b0;
         inc_q     <= '0;
         dec_q     <= '0;
      end else begin
         state_q   <= state_d;
         pend_up_q <= pend_up_d;
         pend_dn_q <= pend_dn_d;
         req_up_q  <= req_up;
         req_dn_q  <= req_dn;
         lvl_q     <= lvl_d;
         dir_q     <= dir_d;
         tick_q    <= tick_d;
         last_q    <= last_d;
         overrun_q <= overrun_d;
         mode_q    <= mode;
         inc_q     <= inc_d;
         dec_q     <= dec_d;
      end
   end

   assign increase = inc_q;
   assign decrease = dec_q;
   assign duty_lvl = lvl_q;
   assign busy     = (state_q != IDLE) || (|pend_any);
   assign overrun  = overrun_q;
endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Bench for pwm_duty_scheduler: scenario tasks checked against a saturating-counter / triangle-ramp model.
`timescale 1ns/1ps
module tb_pwm_duty_scheduler;
   localparam int NCH = 5, STEPS = 10, TICK_DIV = 16;

   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, mode = 1'b0;
   logic [NCH-1:0] req_up = '0, req_dn = '0, increase, decrease;
   logic [4*NCH-1:0] duty_lvl;
   logic busy, overrun;

   int vectors = 0, miscompares = 0, cyc = 0;
   typedef struct {int cyc; int ch; bit up;} ev_t;
   ev_t log_q[$];
   logic [NCH-1:0] prev_stb = '0;
   int m_lvl[NCH];

   pwm_duty_scheduler #(.NCH(NCH), .STEPS(STEPS), .TICK_DIV(TICK_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .req_up(req_up), .req_dn(req_dn),
      .increase(increase), .decrease(decrease), .duty_lvl(duty_lvl), .busy(busy), .overrun(overrun));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Strobe monitor: every strobe must be a single bit lasting a single cycle.
   always @(negedge clk) begin
      if ((increase | decrease) != '0) begin
         vectors++;
         if ($countones(increase | decrease) != 1 || (increase & decrease) != '0 ||
             ((increase | decrease) & prev_stb) != '0) begin
            miscompares++;
            $display("FAIL strobe_shape cyc=%0d inc=%b dec=%b prev=%b (need one bit for one cycle)",
                     cyc, increase, decrease, prev_stb);
         end
         for (int i = 0; i < NCH; i++)
            if (increase[i] || decrease[i]) log_q.push_back('{cyc, i, increase[i]});
      end
      prev_stb = increase | decrease;
   end

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int lvl(input int ch);
      return int'(duty_lvl[4*ch +: 4]);
   endfunction

   // Reference: a saturating 0..STEPS counter per channel; returns whether a strobe is due.
   function automatic bit model_apply(input int ch, input bit up);
      if (up && m_lvl[ch] == STEPS) return 1'b0;
      if (!up && m_lvl[ch] == 0) return 1'b0;
      m_lvl[ch] += up ? 1 : -1;
      return 1'b1;
   endfunction

   task automatic bump(input int ch, input bit up, output int nstb);
      int base, k;
      base = log_q.size();
      if (up) req_up[ch] = 1'b1; else req_dn[ch] = 1'b1;
      step(2);
      k = 0;
      while (busy && k < 10) begin step(1); k++; end
      if (up) req_up[ch] = 1'b0; else req_dn[ch] = 1'b0;
      step(1);
      nstb = log_q.size() - base;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; mode = 1'b0; req_up = '0; req_dn = '0;
      step(2);
      vectors++;
      if ({increase, decrease, duty_lvl, busy, overrun} !== '0) begin
         miscompares++;
         $display("FAIL reset_held got inc=%b dec=%b lvl=%h busy=%b ovr=%b, want all 0",
                  increase, decrease, duty_lvl, busy, overrun);
      end
      rst_n = 1'b1;
      step(3);
      vectors++;
      if ({increase, decrease, duty_lvl, busy, overrun} !== '0) begin
         miscompares++;
         $display("FAIL reset_release got inc=%b dec=%b lvl=%h busy=%b ovr=%b, want all 0",
                  increase, decrease, duty_lvl, busy, overrun);
      end
      foreach (m_lvl[i]) m_lvl[i] = 0;
   endtask

   task automatic test_manual_single();
      logic [NCH-1:0] want;
      want = '0; want[3] = 1'b1;
      req_up[3] = 1'b1;
      step(1);
      vectors++;
      if (increase !== '0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL single_pend inc=%b busy=%b, want inc=0 busy=1", increase, busy);
      end
      step(1);
      vectors++;
      if (increase !== want || decrease !== '0 || lvl(3) != 1) begin
         miscompares++;
         $display("FAIL single_strobe inc=%b dec=%b lvl3=%0d, want inc=%b dec=0 lvl3=1",
                  increase, decrease, lvl(3), want);
      end
      step(1);
      vectors++;
      if (increase !== '0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL single_gap inc=%b busy=%b, want inc=0 busy=1", increase, busy);
      end
      step(1);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_idle busy=%b, want 0", busy);
      end
      req_up[3] = 1'b0;
      step(1);
      void'(model_apply(3, 1'b1));
   endtask

   task automatic test_round_robin();
      int chs[3], base, c0, n;
      bit ups[3];
      chs = '{0, 1, 4};
      ups = '{1'b0, 1'b0, 1'b1};
      for (int j = 0; j < 3; j++)
         while (m_lvl[chs[j]] < 2) begin bump(chs[j], 1'b1, n); void'(model_apply(chs[j], 1'b1)); end
      base = log_q.size(); c0 = cyc;
      req_dn[0] = 1'b1; req_dn[1] = 1'b1; req_up[4] = 1'b1;
      step(12);
      req_dn = '0; req_up = '0;
      step(1);
      vectors++;
      if (log_q.size() - base != 3) begin
         miscompares++;
         $display("FAIL rr_count got %0d strobes, want 3", log_q.size() - base);
      end
      for (int j = 0; j < 3; j++) begin
         if (base + j < log_q.size()) begin
            vectors++;
            if (log_q[base+j].ch != chs[j] || log_q[base+j].up != ups[j] ||
                log_q[base+j].cyc != c0 + 2 + 3*j) begin
               miscompares++;
               $display("FAIL rr_order[%0d] ch=%0d up=%0b cyc=+%0d, want ch=%0d up=%0b cyc=+%0d", j,
                        log_q[base+j].ch, log_q[base+j].up, log_q[base+j].cyc - c0, chs[j], ups[j], 2 + 3*j);
            end
         end
         void'(model_apply(chs[j], ups[j]));
      end
      vectors++;
      if (lvl(0) != 1 || lvl(1) != 1 || lvl(4) != 3) begin
         miscompares++;
         $display("FAIL rr_levels got %0d,%0d,%0d want 1,1,3", lvl(0), lvl(1), lvl(4));
      end
   endtask

   task automatic test_random_manual();
      for (int it = 0; it < 30; it++) begin
         int ch, n;
         bit up, want;
         ch = int'($urandom_range(NCH-1, 0));
         up = 1'($urandom_range(1, 0));
         want = model_apply(ch, up);
         bump(ch, up, n);
         vectors++;
         if (n != int'(want) || lvl(ch) != m_lvl[ch] || busy !== 1'b0 ||
             (n == 1 && (log_q[$].ch != ch || log_q[$].up != up))) begin
            miscompares++;
            $display("FAIL rand_manual it=%0d ch=%0d up=%0b strobes=%0d lvl=%0d busy=%b, want strobes=%0d lvl=%0d busy=0",
                     it, ch, up, n, lvl(ch), busy, want, m_lvl[ch]);
         end
      end
   endtask

   task automatic test_saturation();
      int n;
      while (m_lvl[2] < STEPS) begin bump(2, 1'b1, n); void'(model_apply(2, 1'b1)); end
      bump(2, 1'b1, n);
      vectors++;
      if (n != 0 || lvl(2) != STEPS || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL sat_top strobes=%0d lvl=%0d busy=%b, want 0/%0d/0", n, lvl(2), busy, STEPS);
      end
      while (m_lvl[2] > 0) begin bump(2, 1'b0, n); void'(model_apply(2, 1'b0)); end
      bump(2, 1'b0, n);
      vectors++;
      if (n != 0 || lvl(2) != 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL sat_bottom strobes=%0d lvl=%0d busy=%b, want 0/0/0", n, lvl(2), busy);
      end
   endtask

   task automatic test_cancel();
      int base;
      base = log_q.size();
      req_up[1] = 1'b1; req_dn[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step(1);
         vectors++;
         if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel_busy k=%0d busy=%b, want 0", k, busy);
         end
      end
      req_up[1] = 1'b0; req_dn[1] = 1'b0;
      step(1);
      en = 1'b0;
      req_up[1] = 1'b1;
      step(2);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL cancel_hold busy=%b, want 1", busy);
      end
      req_up[1] = 1'b0; req_dn[1] = 1'b1;
      step(1);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL cancel_opposite busy=%b, want 0", busy);
      end
      req_dn[1] = 1'b0; en = 1'b1;
      step(6);
      vectors++;
      if (log_q.size() != base || lvl(1) != m_lvl[1]) begin
         miscompares++;
         $display("FAIL cancel_nostrobe strobes=%0d lvl=%0d, want 0/%0d", log_q.size() - base, lvl(1), m_lvl[1]);
      end
   endtask

   task automatic test_en_hold();
      int base, old, k;
      bit up;
      up = (m_lvl[0] < STEPS);
      old = m_lvl[0];
      void'(model_apply(0, up));
      en = 1'b0; base = log_q.size();
      if (up) req_up[0] = 1'b1; else req_dn[0] = 1'b1;
      step(1);
      req_up[0] = 1'b0; req_dn[0] = 1'b0;
      step(5);
      vectors++;
      if (log_q.size() != base || busy !== 1'b1 || lvl(0) != old) begin
         miscompares++;
         $display("FAIL en_hold strobes=%0d busy=%b lvl=%0d, want 0/1/%0d", log_q.size() - base, busy, lvl(0), old);
      end
      en = 1'b1;
      k = 0;
      while (log_q.size() == base && k < 10) begin step(1); k++; end
      step(3);
      vectors++;
      if (log_q.size() != base + 1 || lvl(0) != m_lvl[0] || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL en_resume strobes=%0d lvl=%0d busy=%b, want 1/%0d/0", log_q.size() - base, lvl(0), busy, m_lvl[0]);
      end
   endtask

   task automatic test_mode_change();
      int base;
      base = log_q.size();
      en = 1'b0;
      req_up[2] = 1'b1;
      step(1);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL modechg_pend busy=%b, want 1", busy);
      end
      mode = 1'b1;
      step(1);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL modechg_clear busy=%b, want 0", busy);
      end
      mode = 1'b0;
      step(2);
      req_up[2] = 1'b0; en = 1'b1;
      step(4);
      vectors++;
      if (log_q.size() != base || lvl(2) != m_lvl[2] || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL modechg_nostrobe strobes=%0d lvl=%0d busy=%b, want 0/%0d/0", log_q.size() - base, lvl(2), busy, m_lvl[2]);
      end
   endtask

   task automatic test_reset_mid_issue();
      int k;
      logic [NCH-1:0] want;
      want = '0; want[3] = 1'b1;
      if (m_lvl[3] < STEPS) req_up[3] = 1'b1; else req_dn[3] = 1'b1;
      k = 0;
      while ((increase | decrease) == '0 && k < 8) begin step(1); k++; end
      vectors++;
      if ((increase | decrease) !== want) begin
         miscompares++;
         $display("FAIL rst_strobe_seen inc=%b dec=%b, want one strobe on ch3", increase, decrease);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (increase !== '0 || decrease !== '0 || duty_lvl !== '0) begin
         miscompares++;
         $display("FAIL rst_async_drop inc=%b dec=%b lvl=%h, want all 0", increase, decrease, duty_lvl);
      end
      req_up = '0; req_dn = '0;
      step(2);
      rst_n = 1'b1;
      foreach (m_lvl[i]) m_lvl[i] = 0;
      step(1);
      req_up[3] = 1'b1;
      step(1);
      vectors++;
      if (increase !== '0) begin
         miscompares++;
         $display("FAIL rst_latency_early inc=%b, want 0", increase);
      end
      step(1);
      vectors++;
      if (increase !== want || lvl(3) != 1) begin
         miscompares++;
         $display("FAIL rst_latency inc=%b lvl3=%0d, want inc=%b lvl3=1", increase, lvl(3), want);
      end
      req_up[3] = 1'b0;
      step(3);
      void'(model_apply(3, 1'b1));
   endtask

   task automatic test_auto();
      int base, c0;
      const int K = 22;
      rst_n = 1'b0; step(1); rst_n = 1'b1; step(1);
      foreach (m_lvl[i]) m_lvl[i] = 0;
      en = 1'b1; mode = 1'b1;
      base = log_q.size(); c0 = cyc;
      step(16*K + 16);
      vectors++;
      if (log_q.size() <= base || log_q[base].ch != 0 || log_q[base].cyc != c0 + 18) begin
         miscompares++;
         $display("FAIL auto_first_tick first strobe ch=%0d cyc=+%0d, want ch=0 cyc=+18",
                  (log_q.size() > base) ? log_q[base].ch : -1,
                  (log_q.size() > base) ? log_q[base].cyc - c0 : -1);
      end
      // Triangle ramp: one step per tick per channel, turning at STEPS and at 0.
      for (int i = 0; i < NCH; i++) begin
         int lv, cnt;
         bit dn;
         lv = 0; cnt = 0; dn = 1'b0;
         for (int e = base; e < log_q.size(); e++) begin
            if (log_q[e].ch == i) begin
               vectors++;
               if (log_q[e].up != !dn) begin
                  miscompares++;
                  $display("FAIL auto_dir ch=%0d step=%0d up=%0b, want up=%0b", i, cnt, log_q[e].up, !dn);
               end
               cnt++;
               lv += dn ? -1 : 1;
               if (lv == STEPS) dn = 1'b1;
               else if (lv == 0) dn = 1'b0;
            end
         end
         vectors++;
         if (cnt != K || lvl(i) != lv) begin
            miscompares++;
            $display("FAIL auto_ramp ch=%0d strobes=%0d lvl=%0d, want %0d/%0d", i, cnt, lvl(i), K, lv);
         end
      end
      vectors++;
      if (overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL auto_overrun overrun=%b, want 0", overrun);
      end
      mode = 1'b0;
      step(4);
   endtask

   initial begin
      test_reset();
      test_manual_single();
      test_round_robin();
      test_random_manual();
      test_saturation();
      test_cancel();
      test_en_hold();
      test_mode_change();
      test_reset_mid_issue();
      test_auto();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pwm_duty_scheduler.md
PWM_DUTY_SCHEDULER -- requirements
Module: pwm_duty_scheduler

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  NCH, 5, number of pwm_5_variation channels controlled
  STEPS, 10, maximum duty level (levels 0..STEPS)
  TICK_DIV, 16, clk cycles between auto-ramp ticks (>=2)
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  single clock, all state on rising edge
  rst_n  in  1  asynchronous, active-low reset
  en  in  1  1 = scheduler issues strobes; 0 = freeze after current strobe
  mode  in  1  0 = manual (requests), 1 = auto triangle ramp
  req_up  in  NCH  manual increase request per channel, level, synchronous
  req_dn  in  NCH  manual decrease request per channel, level, synchronous
  increase  out  NCH  increase strobe to channel i's increase input
  decrease  out  NCH  decrease strobe to channel i's decrease input
  duty_lvl  out  4*NCH  shadow duty level, channel i in bits [4i+3:4i]
  busy  out  1  high when FSM not IDLE or any pending flag set
  overrun  out  1  sticky, set when an auto tick finds a channel still pending

Function
REQ-003 Rising-edge detect on req_up[i]/req_dn[i] (registered previous value) SHALL set pend_up[i]/pend_dn[i]; flags are sticky until serviced.
REQ-004 Rising edges on both req_up[i] and req_dn[i] in the same cycle, or a new edge opposite an outstanding flag, SHALL clear both flags for that channel (net zero).
REQ-005 FSM states SHALL be IDLE, ISSUE, GAP; IDLE->ISSUE when en=1 and any channel pending; ISSUE->GAP unconditionally; GAP->IDLE unconditionally.
REQ-006 In IDLE, grant SHALL be round-robin: search starts at last_grant+1 modulo NCH; the first pending channel wins.
REQ-007 In ISSUE, exactly one bit of increase or decrease SHALL be high, for exactly one cycle; all strobe bits SHALL be low in IDLE and GAP.
REQ-008 Strobes SHALL be registered outputs; a request edge sampled at edge N with FSM IDLE and no competitor SHALL produce a strobe high from edge N+1 to N+2.
REQ-009 On ISSUE, the granted flag SHALL clear and duty_lvl[i] SHALL increment/decrement at the same edge the strobe rises.
REQ-010 Up request at duty_lvl=STEPS or down request at 0 SHALL clear the flag with no strobe and no FSM transition (saturation, no wrap).
REQ-011 Auto mode: tick counter counts 0..TICK_DIV-1; at wrap, every channel SHALL get pending set in direction dir[i].
REQ-012 dir[i] SHALL flip to down when an up strobe brings duty_lvl to STEPS and to up when a down strobe brings it to 0.
REQ-013 Auto tick finding a channel already pending SHALL leave it pending (no double count) and set overrun.
REQ-014 In auto mode req_up/req_dn SHALL be ignored (edges not captured).
REQ-015 A change of mode SHALL clear all pending flags and the tick counter; any strobe in ISSUE/GAP completes normally.
REQ-016 en=0 SHALL freeze the tick counter and block IDLE->ISSUE; edge capture continues in manual mode.
REQ-017 busy SHALL be combinational: (state!=IDLE) or any pend flag set.

Reset
REQ-018 rst_n low SHALL asynchronously force: state IDLE, increase=0, decrease=0, all pend flags 0, edge registers 0, duty_lvl all 0, dir all up, tick 0, last_grant NCH-1, overrun 0.
REQ-019 Reset asserted mid-ISSUE SHALL drop the strobe immediately; after release the first strobe occurs no earlier than 2 edges after a new request.
REQ-020 overrun SHALL clear only on reset.

Verification
REQ-021 Manual single: mode=0, en=1, req_up[3] 0->1 -> increase[3] high one cycle after 2 edges, duty_lvl ch3=1, busy low after GAP.
REQ-022 Round-robin: edges on req_dn[0], req_dn[1], req_up[4] same cycle with all levels 2 -> strobes in order ch0, ch1, ch4, 3 cycles apart; levels 1,1,3.
REQ-023 Saturation: ch2 at 10, req_up[2] edge -> no strobe, flag clears, level stays 10; ch2 at 0, req_dn[2] -> no strobe.
REQ-024 Cancel: req_up[1] and req_dn[1] rise same cycle -> no strobe on ch1, busy stays low.
REQ-025 Auto: mode=1, TICK_DIV=16 -> each channel ramps 0..10..0, one strobe per channel per tick, dir flips at 10 and 0, overrun stays 0.
REQ-026 Reset mid-ISSUE and en=0 hold: strobes drop to 0 asynchronously, levels 0; with en=0 pending flags persist and strobes resume after en=1.
